// File: rtl/mem_access_ctrl_if.sv
// Data-memory request/response bundle between the control unit, the sequencer
// and the byte-wide synchronous RAM.
interface mem_access_ctrl_if #(parameter int ADDR_W = 9);
  logic              mov;
  logic              rw;
  logic [1:0]        size;
  logic              sign_ext;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              moc;
  logic              busy;
  logic              misalign_err;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic              ram_we;
  logic              ram_re;
  logic [7:0]        ram_rdata;

  modport slave (
    input  mov, rw, size, sign_ext, addr, wdata, ram_rdata,
    output rdata, moc, busy, misalign_err, ram_addr, ram_wdata, ram_we, ram_re
  );

  modport master (
    output mov, rw, size, sign_ext, addr, wdata, ram_rdata,
    input  rdata, moc, busy, misalign_err, ram_addr, ram_wdata, ram_we, ram_re
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Splits byte/half/word memory requests into big-endian byte cycles on a
// byte-wide synchronous RAM and answers on a 4-phase MOV/MOC handshake.
module mem_access_ctrl #(
  parameter int ADDR_W = 9
) (
  input  logic             clk,
  input  logic             reset,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, XFER, WAIT, DONE} state_e;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic [1:0]        size_q, size_d;
  logic              sext_q, sext_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       acc_q, acc_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [1:0]  n_last;
  logic [1:0]  byte_idx;
  logic        last;
  logic        mis_in;
  logic        xfer;
  logic [31:0] acc_shift;

  function automatic logic [31:0] extend(input logic [31:0] a, input logic [1:0] sz,
                                         input logic se);
    case (sz)
      2'b00:   extend = {{24{se & a[7]}}, a[7:0]};
      2'b01:   extend = {{16{se & a[15]}}, a[15:0]};
      default: extend = a;
    endcase
  endfunction

  assign n_last    = (size_q == 2'b10) ? 2'd3 : (size_q == 2'b01) ? 2'd1 : 2'd0;
  assign last      = (cnt_q == n_last);
  assign byte_idx  = n_last - cnt_q;
  assign acc_shift = {acc_q[23:0], bus.ram_rdata};
  assign mis_in    = (bus.size == 2'b11) ||
                     (bus.size == 2'b01 && bus.addr[0]) ||
                     (bus.size == 2'b10 && bus.addr[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      acc_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      acc_q   <= acc_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    size_d  = size_q;
    sext_d  = sext_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    acc_d   = acc_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (bus.mov) begin
        rw_d    = bus.rw;
        size_d  = bus.size;
        sext_d  = bus.sign_ext;
        addr_d  = bus.addr[ADDR_W-1:0];
        wdata_d = bus.wdata;
        cnt_d   = '0;
        acc_d   = '0;
        err_d   = mis_in;
        state_d = mis_in ? DONE : XFER;
      end
      XFER: begin
        // read data trails its strobe by one cycle, so byte 0 arrives while byte 1 issues
        if (rw_q && cnt_q != 2'd0) acc_d = acc_shift;
        if (last) state_d = rw_q ? WAIT : DONE;
        else      cnt_d   = cnt_q + 2'd1;
      end
      WAIT: begin
        acc_d   = acc_shift;
        rdata_d = extend(acc_shift, size_q, sext_q);
        state_d = DONE;
      end
      DONE: if (!bus.mov) begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign xfer             = (state_q == XFER);
  assign bus.ram_we       = xfer & ~rw_q;
  assign bus.ram_re       = xfer & rw_q;
  assign bus.ram_addr     = xfer ? addr_q + ADDR_W'(cnt_q) : '0;
  assign bus.ram_wdata    = (xfer & ~rw_q) ? wdata_q[{byte_idx, 3'b000} +: 8] : 8'h00;
  assign bus.moc          = (state_q == DONE);
  assign bus.misalign_err = (state_q == DONE) & err_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.rdata        = rdata_q;

endmodule
